// File: rtl/bf_pkg.sv
// Shared definitions for the bit-flipping decoder control path: FSM state
// encoding and default widths common with the syndrome-weight adder.
package bf_pkg;

    localparam int BF_SUM_BITS  = 8;
    localparam int BF_ITER_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WT = 2'd1,
        ST_FLIP    = 2'd2,
        ST_FIN     = 2'd3
    } bf_state_e;

endpackage

// File: rtl/bf_stall_mon.sv
// Stall monitor: counts consecutive syndrome-weight samples that fail to beat
// the best weight so far and flags when the run length reaches STALL_LIMIT.
module bf_stall_mon
    import bf_pkg::*;
#(
    parameter int SUM_BITS    = BF_SUM_BITS,
    parameter int STALL_LIMIT = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_sample,
    input  logic [SUM_BITS-1:0] i_wt,
    input  logic [SUM_BITS-1:0] i_best_wt,
    output logic                o_hit
);

    localparam int CW = $clog2(STALL_LIMIT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_nonimp;
    logic [CW:0]   w_cnt_inc;

    // i_best_wt is the value before this sample's min-update, so equality counts as no progress
    assign w_nonimp  = (i_wt >= i_best_wt);
    assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
    assign o_hit     = i_sample && w_nonimp && (w_cnt_inc >= (CW + 1)'(STALL_LIMIT));

    // Run-length counter of non-improving samples, cleared on new codeword
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_sample) begin
            r_cnt <= w_nonimp ? w_cnt_inc[CW-1:0] : {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/bf_term_ctrl.sv
// Iteration/termination controller for the bit-flipping LDPC decoder.
// Optional early stop on stalled progress is built when BF_STALL_DETECT_EN is defined.
module bf_term_ctrl
    import bf_pkg::*;
#(
    parameter int SUM_BITS    = BF_SUM_BITS,
    parameter int MAX_ITER    = 20,
    parameter int ITER_BITS   = BF_ITER_BITS,
    parameter int STALL_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 wt_valid,
    input  logic [SUM_BITS-1:0]  wt,
    output logic                 flip_req,
    input  logic                 flip_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 success,
    output logic                 stall,
    output logic [ITER_BITS-1:0] iter_cnt,
    output logic [SUM_BITS-1:0]  best_wt
);

    bf_state_e            r_state;
    logic                 r_flip_req;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_success;
    logic [ITER_BITS-1:0] r_iter_cnt;
    logic [SUM_BITS-1:0]  r_best_wt;
    logic                 w_start_acc;
    logic                 w_sample;
    logic [SUM_BITS-1:0]  w_min_wt;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_sample    = (r_state == ST_WAIT_WT) && wt_valid;
    assign w_min_wt    = (wt < r_best_wt) ? wt : r_best_wt;

`ifdef BF_STALL_DETECT_EN
    logic r_stall;
    logic w_stall_hit;

    bf_stall_mon #(
        .SUM_BITS    (SUM_BITS),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_mon (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_start_acc),
        .i_sample  (w_sample),
        .i_wt      (wt),
        .i_best_wt (r_best_wt),
        .o_hit     (w_stall_hit)
    );

    assign stall = r_stall;
`else
    assign stall = 1'b0;
`endif

    assign flip_req = r_flip_req;
    assign busy     = r_busy;
    assign done     = r_done;
    assign success  = r_success;
    assign iter_cnt = r_iter_cnt;
    assign best_wt  = r_best_wt;

    // Decode sequencing FSM with all status outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_flip_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_success  <= 1'b0;
            r_iter_cnt <= {ITER_BITS{1'b0}};
            r_best_wt  <= {SUM_BITS{1'b1}};
`ifdef BF_STALL_DETECT_EN
            r_stall    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_acc) begin
                        r_state    <= ST_WAIT_WT;
                        r_busy     <= 1'b1;
                        r_success  <= 1'b0;
                        r_iter_cnt <= {ITER_BITS{1'b0}};
                        r_best_wt  <= {SUM_BITS{1'b1}};
`ifdef BF_STALL_DETECT_EN
                        r_stall    <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_WT: begin
                    if (w_sample) begin
                        r_best_wt <= w_min_wt;
                        // Convergence outranks the iteration cap, which outranks stall
                        if (wt == {SUM_BITS{1'b0}}) begin
                            r_state   <= ST_FIN;
                            r_done    <= 1'b1;
                            r_success <= 1'b1;
                        end else if (r_iter_cnt == ITER_BITS'(MAX_ITER)) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
`ifdef BF_STALL_DETECT_EN
                        end else if (w_stall_hit) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_stall <= 1'b1;
`endif
                        end else begin
                            r_state    <= ST_FLIP;
                            r_flip_req <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_WAIT_WT;
                    end
                end
                ST_FLIP: begin
                    if (flip_ack) begin
                        r_state    <= ST_WAIT_WT;
                        r_flip_req <= 1'b0;
                        r_iter_cnt <= r_iter_cnt + {{(ITER_BITS-1){1'b0}}, 1'b1};
                    end else begin
                        r_state <= ST_FLIP;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_flip_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
